// File: rtl/div16by8_r4_seq_pkg.sv
// Shared types and sizing for the radix-4 sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIV_W = 8;
    localparam int ITER  = DIV_W / 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

endpackage

// File: rtl/div16by8_r4_seq_if.sv
// Operand/result handshake bundle for the divider.
interface div16by8_r4_seq_if #(
    parameter int W = div_pkg::DIV_W
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output div_zero, overflow
    );
endinterface

// File: rtl/div16by8_r4_seq_step.sv
// One radix-4 restoring step: pick the largest digit d with d*B <= t.
module div_r4_step #(
    parameter int W = div_pkg::DIV_W
) (
    input  logic [W+1:0] t,
    input  logic [W+1:0] b1,
    input  logic [W+1:0] b2,
    input  logic [W+1:0] b3,
    output logic [1:0]   digit,
    output logic [W-1:0] rem
);
    logic [W-1:0] sub;

    // The true remainder is below B, so W-bit modular subtraction is exact.
    always_comb begin
        digit = 2'd0;
        sub   = '0;
        if (t >= b3) begin
            digit = 2'd3;
            sub   = b3[W-1:0];
        end else if (t >= b2) begin
            digit = 2'd2;
            sub   = b2[W-1:0];
        end else if (t >= b1) begin
            digit = 2'd1;
            sub   = b1[W-1:0];
        end
        rem = t[W-1:0] - sub;
    end
endmodule

// File: rtl/div16by8_r4_seq.sv
// Sequential radix-4 unsigned divider, 2W/W -> W quotient, W remainder.
module div16by8_r4_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    div16by8_r4_seq_if.slave bus
);
    localparam int IT = W / 2;
    localparam int CW = (IT > 1) ? $clog2(IT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  b_q, b_d;
    logic [W+1:0]  b3_q, b3_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  q_q, q_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dzo_q, dzo_d;
    logic          ovo_q, ovo_d;

    logic [W+1:0]  t;
    logic [1:0]    digit;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  p_hi;

    assign t    = {r_q, s_q[W-1:W-2]};
    assign p_hi = bus.dividend[2*W-1:W];

    div_r4_step #(.W(W)) u_step (
        .t     (t),
        .b1    ({2'b00, b_q}),
        .b2    ({1'b0, b_q, 1'b0}),
        .b3    (b3_q),
        .digit (digit),
        .rem   (step_rem)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        b3_d        = b3_q;
        r_d         = r_q;
        s_d         = s_q;
        q_d         = q_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dzo_d       = dzo_q;
        ovo_d       = ovo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    b_d        = bus.divisor;
                    b3_d       = {2'b00, bus.divisor}
                               + {1'b0, bus.divisor, 1'b0};
                    r_d        = p_hi;
                    s_d        = bus.dividend[W-1:0];
                    q_d        = '0;
                    cnt_d      = '0;
                    dz_d       = (bus.divisor == '0);
                    ov_d       = (bus.divisor != '0)
                               && (p_hi >= bus.divisor);
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                // Error cases spend a single RUN cycle, then report.
                if (dz_q || ov_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quo_d       = '1;
                    rem_d       = '0;
                    dzo_d       = dz_q;
                    ovo_d       = ov_q;
                end else begin
                    s_d   = {s_q[W-3:0], 2'b00};
                    r_d   = step_rem;
                    q_d   = {q_q[W-3:0], digit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(IT - 1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quo_d       = {q_q[W-3:0], digit};
                        rem_d       = step_rem;
                        dzo_d       = 1'b0;
                        ovo_d       = 1'b0;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            b_q         <= '0;
            b3_q        <= '0;
            r_q         <= '0;
            s_q         <= '0;
            q_q         <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dzo_q       <= 1'b0;
            ovo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            b3_q        <= b3_d;
            r_q         <= r_d;
            s_q         <= s_d;
            q_q         <= q_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dzo_q       <= dzo_d;
            ovo_q       <= ovo_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dzo_q;
    assign bus.overflow  = ovo_q;
endmodule

// File: tb/tb_div16by8_r4_seq.sv
// Bench for div16by8_r4_seq: vector table, corner sequences, random round-trip.
module tb_div16by8_r4_seq;
    import div_pkg::*;

    typedef struct {
        logic [15:0] p;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div16by8_r4_seq_if dif ();

    div16by8_r4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    vec_t sb[$];
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result is consumed at the next rising edge; compare it here.
    always @(negedge clk) begin
        if (rst_n && dif.out_valid && dif.out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got q=%h r=%h expected none",
                         dif.quotient, dif.remainder);
            end else begin
                vec_t e;
                e = sb.pop_front();
                if (dif.quotient !== e.q || dif.remainder !== e.r ||
                    dif.div_zero !== e.dz || dif.overflow !== e.ov) begin
                    n_bad++;
                    $display("FAIL result P=%h B=%h: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                             e.p, e.b, dif.quotient, dif.remainder,
                             dif.div_zero, dif.overflow, e.q, e.r, e.dz, e.ov);
                end
            end
        end
    end

    task automatic send(input vec_t v);
        dif.dividend = v.p;
        dif.divisor  = v.b;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                @(posedge clk);
                sb.push_back(v);
                #1;
                dif.in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
        dif.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
        end
        n_vec++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        sb.delete();
    endtask

    task automatic latency(input vec_t v, input int edges);
        int n;
        dif.out_ready = 1'b0;
        send(v);
        n = 0;
        while (!dif.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, edges);
        dif.out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0};
        tbl[1]  = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0};
        tbl[10] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0};

        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_in_ready", dif.in_ready, 1);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_quotient", dif.quotient, 0);
        check("rst_remainder", dif.remainder, 0);
        check("rst_flags", {dif.div_zero, dif.overflow}, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) send(tbl[i]);
        drain();

        latency(tbl[0], ITER);
        latency(tbl[2], 1);
        latency(tbl[3], 1);

        // Hold the result while pulsing in_valid with other operands.
        dif.out_ready = 1'b0;
        send(tbl[0]);
        for (int i = 0; i < 20 && !dif.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            dif.in_valid = (i % 2 == 0);
            dif.dividend = 16'($urandom);
            dif.divisor  = 8'h03;
            @(negedge clk);
            check("hold_out_valid", dif.out_valid, 1);
            check("hold_in_ready", dif.in_ready, 0);
            check("hold_q_r", {dif.quotient, dif.remainder}, 16'h8E06);
        end
        @(posedge clk);
        #1;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("hold_no_extra", dif.out_valid, 0);
        end
        check("hold_in_ready_after", dif.in_ready, 1);

        // Abort mid-RUN once cnt has reached 2.
        @(posedge clk);
        #1;
        send(tbl[0]);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", dif.out_valid, 0);
        check("abort_in_ready", dif.in_ready, 1);
        @(posedge clk);
        #1;
        send(tbl[10]);
        drain();
        repeat (6) begin
            @(negedge clk);
            check("abort_discarded", dif.out_valid, 0);
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 10000; i++) begin
            int a, b, r;
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(255, 1));
            r = int'($urandom_range(b - 1, 0));
            v.p  = 16'(a * b + r);
            v.b  = 8'(b);
            v.q  = 8'(a);
            v.r  = 8'(r);
            v.dz = 1'b0;
            v.ov = 1'b0;
            send(v);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
